ttt_game_ctrl: RTL and testbench
================================

Name: ttt_game_ctrl

Overview:
- Sequential game controller, directly downstream of the two-in-a-row detectors; consumes their per-square masks.
- Owns board registers x_board (human) and o_board (computer). Accepts human moves over a valid/ready handshake.
- Picks the computer's move by priority: win, block, center, corner, side. Then detects win or draw.
- The two external detector instances are fed combinationally from this block's board outputs: win check (a=o_board, b=x_board) and block check (a=x_board, b=o_board).

Parameters:
- USE_BLOCK, 1, when 0 the block step is skipped (easy mode).
- CORNER_FIRST, 1, when 0 sides are tried before corners.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear board, begin a new game
- human_first  in  1  sampled with start; 1 means the human moves first
- move_valid  in  1  human move offered
- move_idx  in  4  human square, 0..8, row-major
- move_ready  out  1  high only in WAIT_H
- win_mask  in  9  squares that complete an o line
- block_mask  in  9  squares that complete an x line
- x_board  out  9  human pieces
- o_board  out  9  computer pieces
- comp_valid  out  1  one-cycle pulse when the computer places a piece
- comp_idx  out  4  square of that placement; held until the next placement
- illegal  out  1  one-cycle pulse: rejected human move
- game_over  out  1  high in DONE
- winner  out  2  00 none/draw, 01 x, 10 o; valid when game_over is high

Behaviour:
- Reset state: IDLE; x_board=o_board=0, comp_idx=0, winner=00; all pulse outputs 0.
- States: IDLE, WAIT_H, CHK_H, COMP, CHK_C, DONE.
- start, from any state, has priority over all else:
  - clears both boards and winner;
  - next state is WAIT_H if human_first=1, else COMP.
  - No other action that cycle.
- IDLE: waits for start.
- WAIT_H handshake:
  - Transfer occurs when move_valid && move_ready.
  - Legal move: move_idx<9 and the square is empty in x_board|o_board.
  - Legal: x_board[move_idx] is set at that edge; next state CHK_H.
  - Illegal: illegal pulses the next cycle; stay in WAIT_H; boards unchanged.
- CHK_H:
  - x has three in a line: DONE, winner=01.
  - Else board full (x|o==9'h1FF): DONE, winner=00.
  - Else: COMP.
- COMP: selected square sel, where empty = ~(x|o):
  1. lowest set bit of win_mask&empty;
  2. else, if USE_BLOCK=1, lowest set bit of block_mask&empty;
  3. else square 4 if empty;
  4. else first empty corner in order 0,2,6,8 (sides first if CORNER_FIRST=0);
  5. else first empty side in order 1,3,5,7.
  - On exit: o_board[sel] is set, comp_idx=sel, and comp_valid pulses the cycle after COMP; next state CHK_C.
  - COMP is entered only when at least one empty square exists.
- CHK_C: same tests as CHK_H on o.
  - o line: DONE, winner=10.
  - Else full: DONE, winner=00.
  - Else: WAIT_H.
- Latency:
  - Human accept to comp_valid: 3 cycles (CHK_H, COMP, CHK_C entry).
  - Masks are read in COMP against boards already updated in CHK_H.
- DONE: boards and winner frozen; move_ready=0; move_valid is ignored with no illegal pulse. Exits only on start.
- reset mid-game: asynchronous clear to the reset state above.
- Masks are only sampled in COMP; stale or glitching values in other states are don't-care.

Decomposition:
- Package ttt_pkg holds:
  - state enum;
  - the 8 line-mask constants (rows, columns, diagonals);
  - constants CENTER=4, CORNERS, SIDES;
  - winner encoding constants.
- Sub-module three_in_array (combinational): 9-bit board in, 1-bit "any complete line" out, using the line masks. Instantiated twice (x, o).
- Lowest-set-bit picker as a function in ttt_pkg.

Test Plan:
- Reset then start with human_first=1; human plays 0 -> x_board=001; comp_valid after 3 cycles with comp_idx=4.
- Win priority: board x={0,1,5}, o={4,8}, COMP entered with win_mask having bit 6 set and block_mask having bit 2 set -> comp_idx=6 (not 2).
- Block:
  - x={0,1}, o={4}, block_mask bit 2, win_mask=0 -> comp_idx=2.
  - Same stimulus with USE_BLOCK=0 -> comp_idx=2 via the corner rule (0 taken). Repeat with x={1,7}, o={4}, block_mask=0 -> comp_idx=0.
- Illegal moves:
  - move_idx=9 -> illegal pulse, boards unchanged.
  - Occupied square 4 -> illegal pulse; state stays WAIT_H.
- Human wins along x={2,4,6} -> game_over=1, winner=01, move_ready=0. Full draw sequence -> winner=00.
- Reset and restart:
  - Assert rst_n=0 mid-COMP -> boards 0, state IDLE immediately.
  - start in DONE with human_first=0 -> boards cleared, comp_idx=4 two cycles later.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
package ttt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_H,
        S_CHK_H,
        S_COMP,
        S_CHK_C,
        S_DONE
    } state_t;

    // Three rows, three columns, then the two diagonals (bit n = square n, row-major).
    localparam int unsigned N_LINES = 8;
    localparam logic [N_LINES-1:0][8:0] LINE_MASKS = {
        9'h054, 9'h111,
        9'h124, 9'h092, 9'h049,
        9'h1C0, 9'h038, 9'h007
    };

    localparam logic [3:0] CENTER  = 4'd4;
    // Corners 0,2,6,8 and sides 1,3,5,7; ascending bit order gives the scan order.
    localparam logic [8:0] CORNERS = 9'h145;
    localparam logic [8:0] SIDES   = 9'h0AA;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] lowest_set(input logic [8:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 9; i > 0; i--) begin
            if (v[i-1]) idx = 4'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ttt_game_ctrl_three_in_array.sv
// Combinational check: does the board contain any complete line?
module three_in_array
    import ttt_pkg::*;
(
    input  logic [8:0] i_board,
    output logic       o_line
);

    // OR of all eight line matches.
    always_comb begin
        o_line = 1'b0;
        for (int unsigned i = 0; i < N_LINES; i++) begin
            if ((i_board & LINE_MASKS[i]) == LINE_MASKS[i]) o_line = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: human moves in over valid/ready, computer picks
// win > block > center > corner > side, then detects win or draw.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter bit USE_BLOCK    = 1'b1,
    parameter bit CORNER_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       human_first,
    input  logic       move_valid,
    input  logic [3:0] move_idx,
    output logic       move_ready,
    input  logic [8:0] win_mask,
    input  logic [8:0] block_mask,
    output logic [8:0] x_board,
    output logic [8:0] o_board,
    output logic       comp_valid,
    output logic [3:0] comp_idx,
    output logic       illegal,
    output logic       game_over,
    output logic [1:0] winner
);

    state_t     r_state;
    logic [8:0] r_x;
    logic [8:0] r_o;
    logic [3:0] r_comp_idx;
    logic       r_comp_valid;
    logic       r_illegal;
    logic [1:0] r_winner;

    logic       w_x_line;
    logic       w_o_line;
    logic       w_full;
    logic [8:0] w_empty;
    logic [8:0] w_win;
    logic [8:0] w_blk;
    logic       w_legal;
    logic [3:0] w_sel;

    three_in_array u_x_line (.i_board(r_x), .o_line(w_x_line));
    three_in_array u_o_line (.i_board(r_o), .o_line(w_o_line));

    assign w_empty = ~(r_x | r_o);
    assign w_full  = ((r_x | r_o) == 9'h1FF);
    assign w_win   = win_mask & w_empty;
    assign w_blk   = block_mask & w_empty;

    // Human move legality: in range and on an empty square.
    always_comb begin
        w_legal = 1'b0;
        if (move_idx < 4'd9) w_legal = w_empty[move_idx];
    end

    // Computer move selection in priority order.
    always_comb begin
        w_sel = '0;
        if (|w_win) begin
            w_sel = lowest_set(w_win);
        end else if (USE_BLOCK && (|w_blk)) begin
            w_sel = lowest_set(w_blk);
        end else if (w_empty[CENTER]) begin
            w_sel = CENTER;
        end else if (CORNER_FIRST) begin
            w_sel = (|(w_empty & CORNERS)) ? lowest_set(w_empty & CORNERS)
                                           : lowest_set(w_empty & SIDES);
        end else begin
            w_sel = (|(w_empty & SIDES)) ? lowest_set(w_empty & SIDES)
                                         : lowest_set(w_empty & CORNERS);
        end
    end

    // Game FSM with boards, winner and pulse outputs all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_o          <= '0;
            r_comp_idx   <= '0;
            r_comp_valid <= 1'b0;
            r_illegal    <= 1'b0;
            r_winner     <= WIN_NONE;
        end else begin
            r_comp_valid <= 1'b0;
            r_illegal    <= 1'b0;
            if (start) begin
                r_x      <= '0;
                r_o      <= '0;
                r_winner <= WIN_NONE;
                r_state  <= human_first ? S_WAIT_H : S_COMP;
            end else begin
                case (r_state)
                    S_WAIT_H: begin
                        if (move_valid) begin
                            if (w_legal) begin
                                r_x[move_idx] <= 1'b1;
                                r_state       <= S_CHK_H;
                            end else begin
                                r_illegal <= 1'b1;
                            end
                        end
                    end
                    S_CHK_H: begin
                        if (w_x_line) begin
                            r_winner <= WIN_X;
                            r_state  <= S_DONE;
                        end else if (w_full) begin
                            r_winner <= WIN_NONE;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_COMP;
                        end
                    end
                    S_COMP: begin
                        r_o[w_sel]   <= 1'b1;
                        r_comp_idx   <= w_sel;
                        r_comp_valid <= 1'b1;
                        r_state      <= S_CHK_C;
                    end
                    S_CHK_C: begin
                        if (w_o_line) begin
                            r_winner <= WIN_O;
                            r_state  <= S_DONE;
                        end else if (w_full) begin
                            r_winner <= WIN_NONE;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_WAIT_H;
                        end
                    end
                    S_IDLE, S_DONE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign move_ready = (r_state == S_WAIT_H);
    assign game_over  = (r_state == S_DONE);
    assign x_board    = r_x;
    assign o_board    = r_o;
    assign comp_valid = r_comp_valid;
    assign comp_idx   = r_comp_idx;
    assign illegal    = r_illegal;
    assign winner     = r_winner;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: three parameter variants, scoreboard of
// expected computer moves checked whenever comp_valid pulses.
module tb_ttt_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st [3];
    logic       hf [3];
    logic       mv [3];
    logic [3:0] mi [3];
    logic [8:0] wm [3];
    logic [8:0] bm [3];
    logic       mr [3];
    logic [8:0] xb [3];
    logic [8:0] ob [3];
    logic       cv [3];
    logic [3:0] ci [3];
    logic       il [3];
    logic       go [3];
    logic [1:0] wn [3];

    localparam bit UB [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit CF [3] = '{1'b1, 1'b1, 1'b0};

    ttt_game_ctrl #(.USE_BLOCK(1'b1), .CORNER_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .human_first(hf[0]),
        .move_valid(mv[0]), .move_idx(mi[0]), .move_ready(mr[0]),
        .win_mask(wm[0]), .block_mask(bm[0]), .x_board(xb[0]), .o_board(ob[0]),
        .comp_valid(cv[0]), .comp_idx(ci[0]), .illegal(il[0]),
        .game_over(go[0]), .winner(wn[0])
    );

    ttt_game_ctrl #(.USE_BLOCK(1'b0), .CORNER_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .human_first(hf[1]),
        .move_valid(mv[1]), .move_idx(mi[1]), .move_ready(mr[1]),
        .win_mask(wm[1]), .block_mask(bm[1]), .x_board(xb[1]), .o_board(ob[1]),
        .comp_valid(cv[1]), .comp_idx(ci[1]), .illegal(il[1]),
        .game_over(go[1]), .winner(wn[1])
    );

    ttt_game_ctrl #(.USE_BLOCK(1'b1), .CORNER_FIRST(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .human_first(hf[2]),
        .move_valid(mv[2]), .move_idx(mi[2]), .move_ready(mr[2]),
        .win_mask(wm[2]), .block_mask(bm[2]), .x_board(xb[2]), .o_board(ob[2]),
        .comp_valid(cv[2]), .comp_idx(ci[2]), .illegal(il[2]),
        .game_over(go[2]), .winner(wn[2])
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] exp_q [$];
    logic [8:0] mx;
    logic [8:0] mo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_line(input logic [8:0] b);
        bit r;
        r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (b[3*k] && b[3*k+1] && b[3*k+2]) r = 1'b1;
            if (b[k] && b[k+3] && b[k+6]) r = 1'b1;
        end
        if (b[0] && b[4] && b[8]) r = 1'b1;
        if (b[2] && b[4] && b[6]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] pick(input logic [8:0] x, input logic [8:0] o,
                                        input logic [8:0] w, input logic [8:0] bl,
                                        input bit ub, input bit cf);
        logic [8:0] e;
        int ord [8];
        e = ~(x | o);
        for (int i = 0; i < 9; i++) if (w[i] && e[i]) return 4'(i);
        if (ub) for (int i = 0; i < 9; i++) if (bl[i] && e[i]) return 4'(i);
        if (e[4]) return 4'd4;
        if (cf) ord = '{0, 2, 6, 8, 1, 3, 5, 7};
        else    ord = '{1, 3, 5, 7, 0, 2, 6, 8};
        for (int k = 0; k < 8; k++) if (e[ord[k]]) return 4'(ord[k]);
        return 4'hF;
    endfunction

    // Scoreboard: every comp_valid pulse must match the next queued expectation.
    always @(negedge clk) begin : mon
        logic [3:0] e;
        for (int d = 0; d < 3; d++) begin
            if (cv[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("comp_spurious", 32'(cv[d]), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("comp_idx", 32'(ci[d]), 32'(e));
                end
            end
        end
    end

    task automatic check_boards(input int d);
        chk("x_board", 32'(xb[d]), 32'(mx));
        chk("o_board", 32'(ob[d]), 32'(mo));
    endtask

    task automatic end_check(input int d, input logic [8:0] b, input logic [1:0] who);
        if (has_line(b)) begin
            chk("game_over", 32'(go[d]), 32'd1);
            chk("winner", 32'(wn[d]), 32'(who));
            chk("ready_done", 32'(mr[d]), 32'd0);
        end else if ((mx | mo) == 9'h1FF) begin
            chk("game_over", 32'(go[d]), 32'd1);
            chk("winner_draw", 32'(wn[d]), 32'd0);
            chk("ready_done", 32'(mr[d]), 32'd0);
        end else begin
            chk("game_over", 32'(go[d]), 32'd0);
            chk("move_ready", 32'(mr[d]), 32'd1);
        end
        check_boards(d);
    endtask

    task automatic comp_turn(input int d, input int lat);
        logic [3:0] s;
        int n;
        s = pick(mx, mo, wm[d], bm[d], UB[d], CF[d]);
        exp_q.push_back(s);
        mo[s] = 1'b1;
        n = 1;
        while (cv[d] !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("comp_latency", 32'(n), 32'(lat));
        @(negedge clk);
        end_check(d, mo, 2'b10);
    endtask

    task automatic start_game(input int d, input logic h);
        wm[d] = '0; bm[d] = '0;
        st[d] = 1'b1; hf[d] = h;
        @(negedge clk);
        st[d] = 1'b0;
        mx = '0; mo = '0;
        check_boards(d);
        chk("winner_clr", 32'(wn[d]), 32'd0);
        chk("over_clr", 32'(go[d]), 32'd0);
        if (h) chk("move_ready", 32'(mr[d]), 32'd1);
        else   comp_turn(d, 2);
    endtask

    task automatic play(input int d, input logic [3:0] idx, input logic [8:0] w, input logic [8:0] b);
        chk("move_ready", 32'(mr[d]), 32'd1);
        wm[d] = w; bm[d] = b; mi[d] = idx; mv[d] = 1'b1;
        @(negedge clk);
        mv[d] = 1'b0;
        mx[idx] = 1'b1;
        if (has_line(mx) || ((mx | mo) == 9'h1FF)) begin
            @(negedge clk);
            end_check(d, mx, 2'b01);
        end else begin
            comp_turn(d, 3);
        end
    endtask

    task automatic illegal_try(input int d, input logic [3:0] idx);
        mi[d] = idx; mv[d] = 1'b1;
        @(negedge clk);
        mv[d] = 1'b0;
        chk("illegal_pulse", 32'(il[d]), 32'd1);
        chk("illegal_ready", 32'(mr[d]), 32'd1);
        check_boards(d);
        @(negedge clk);
        chk("illegal_clear", 32'(il[d]), 32'd0);
    endtask

    task automatic done_ignore(input int d);
        mi[d] = 4'd3; mv[d] = 1'b1;
        @(negedge clk);
        mv[d] = 1'b0;
        @(negedge clk);
        chk("done_no_illegal", 32'(il[d]), 32'd0);
        chk("done_held", 32'(go[d]), 32'd1);
        check_boards(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0; hf[d] = 1'b0; mv[d] = 1'b0;
            mi[d] = '0; wm[d] = '0; bm[d] = '0;
        end
        mx = '0; mo = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_boards(d);
            chk("rst_comp_idx", 32'(ci[d]), 32'd0);
            chk("rst_winner", 32'(wn[d]), 32'd0);
            chk("rst_comp_valid", 32'(cv[d]), 32'd0);
            chk("rst_illegal", 32'(il[d]), 32'd0);
            chk("rst_game_over", 32'(go[d]), 32'd0);
            chk("rst_ready", 32'(mr[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Win priority, illegal moves, human row win, ignored move in DONE.
        start_game(0, 1'b1);
        play(0, 4'd0, 9'h000, 9'h000);
        play(0, 4'd1, 9'h100, 9'h000);
        play(0, 4'd5, 9'h040, 9'h004);
        illegal_try(0, 4'd9);
        illegal_try(0, 4'd4);
        play(0, 4'd2, 9'h000, 9'h000);
        done_ignore(0);

        // Human diagonal 2,4,6.
        start_game(0, 1'b1);
        play(0, 4'd4, 9'h000, 9'h000);
        play(0, 4'd2, 9'h100, 9'h000);
        play(0, 4'd6, 9'h000, 9'h000);

        // Block then play out to a draw.
        start_game(0, 1'b1);
        play(0, 4'd0, 9'h000, 9'h000);
        play(0, 4'd1, 9'h000, 9'h004);
        play(0, 4'd6, 9'h000, 9'h000);
        play(0, 4'd5, 9'h000, 9'h000);
        play(0, 4'd7, 9'h000, 9'h000);

        // Restart from DONE with computer first, then reset while in COMP.
        start_game(0, 1'b0);
        chk("move_ready", 32'(mr[0]), 32'd1);
        mi[0] = 4'd0; mv[0] = 1'b1;
        @(negedge clk);
        mv[0] = 1'b0;
        @(negedge clk);
        chk("pre_rst_x", 32'(xb[0]), 32'h001);
        rst_n = 1'b0;
        #1;
        chk("async_rst_x", 32'(xb[0]), 32'd0);
        chk("async_rst_o", 32'(ob[0]), 32'd0);
        chk("async_rst_ready", 32'(mr[0]), 32'd0);
        chk("async_rst_idx", 32'(ci[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(mr[0]), 32'd0);
        chk("idle_over", 32'(go[0]), 32'd0);
        chk("idle_no_comp", 32'(cv[0]), 32'd0);

        // Easy mode: block step skipped.
        start_game(1, 1'b1);
        play(1, 4'd0, 9'h000, 9'h000);
        play(1, 4'd1, 9'h000, 9'h004);
        start_game(1, 1'b1);
        play(1, 4'd1, 9'h000, 9'h000);
        play(1, 4'd7, 9'h000, 9'h000);

        // Sides before corners, then computer wins column 1,4,7.
        start_game(2, 1'b1);
        play(2, 4'd0, 9'h000, 9'h000);
        play(2, 4'd8, 9'h000, 9'h000);
        play(2, 4'd3, 9'h080, 9'h000);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
